// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with count, full/empty, almost flags and sticky errors.
// Ports: clk, rst_n, flush, wr_en, din, rd_en, err_clr -> dout, full, empty,
//   almost_full, almost_empty, count, overflow, underflow.
//   Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_nxt;
  logic             wr_do;
  logic             rd_do;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // flush wins over both accesses
  assign wr_do = wr_en & ~full & ~flush;
  assign rd_do = rd_en & ~empty & ~flush;

  always_comb begin
    cnt_nxt = count;
    unique case (1'b1)
      flush:          cnt_nxt = '0;
      wr_do & ~rd_do: cnt_nxt = count + CW'(1);
      rd_do & ~wr_do: cnt_nxt = count - CW'(1);
      default:        cnt_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= cnt_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_do)
          wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
        if (rd_do)
          rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      // a new error beats a simultaneous clear
      overflow  <= (wr_en & full) | (overflow & ~err_clr);
      underflow <= (rd_en & empty) | (underflow & ~err_clr);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = empty ? '0 : mem[rd_ptr];
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dout_q <= '0;
    else if (rd_do)
      dout_q <= mem[rd_ptr];
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags at DEPTH=5 with a queue scoreboard.
// Checks flags, count, sticky errors, flush, reset and read data order.
module tb_sync_fifo_flags;

  localparam int W = 8;
  localparam int D = 5;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [W-1:0]  din;
  logic          rd_en;
  logic          err_clr;
  logic [W-1:0]  dout;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  sync_fifo_flags #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .err_clr      (err_clr),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int           n_pass = 0;
  int           n_tot  = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] exp_dout = '0;
  logic         m_ov = 1'b0;
  logic         m_un = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [W-1:0] ed;
    n = q.size();
`ifdef SYNC_FIFO_FWFT_EN
    ed = (n > 0) ? q[0] : '0;
`else
    ed = exp_dout;
`endif
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".full"}, 32'(full), 32'(n == D));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".af"}, 32'(almost_full), 32'(n >= D - 2));
    chk({tag, ".ae"}, 32'(almost_empty), 32'(n <= 2));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_un));
    chk({tag, ".dout"}, 32'(dout), 32'(ed));
  endtask

  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r,
                     input logic f, input logic ec, input string tag);
    logic fm, em, wa, ra;
    fm = (q.size() == D);
    em = (q.size() == 0);
    wa = w && !fm && !f;
    ra = r && !em && !f;
    wr_en = w; din = d; rd_en = r; flush = f; err_clr = ec;
    @(posedge clk);
    #1;
    m_ov = (w && fm) || (m_ov && !ec);
    m_un = (r && em) || (m_un && !ec);
    if (f) q.delete();
    else begin
      if (ra) exp_dout = q.pop_front();
      if (wa) q.push_back(d);
    end
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; din = '0;
    rd_en = 1'b0; err_clr = 1'b0;
    #12;
    check_all("reset");
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) cyc(1, W'(8'h11 + i), 0, 0, 0, "fill");
    cyc(1, 8'h16, 0, 0, 0, "ovf_write");
    cyc(1, 8'h17, 0, 0, 1, "set_wins");
    cyc(0, 8'h00, 0, 0, 1, "ovf_clr");

    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 0, "drain");
    cyc(0, 8'h00, 1, 0, 0, "unf_read");
    cyc(0, 8'h00, 0, 0, 1, "unf_clr");

    for (int i = 0; i < 5; i++) cyc(1, W'(8'h21 + i), 0, 0, 0, "fill2");
    cyc(1, 8'h99, 1, 0, 0, "full_wr_rd");
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0, 0, "drain2");
    cyc(1, 8'h77, 1, 0, 0, "empty_wr_rd");
    cyc(0, 8'h00, 1, 0, 1, "read_77");

    cyc(1, 8'hA5, 0, 0, 0, "wr_a5");
    cyc(0, 8'h00, 1, 0, 0, "rd_a5");

    cyc(0, 8'h00, 1, 0, 0, "unf_again");
    for (int i = 0; i < 6; i++) cyc(1, W'(8'h31 + i), 0, 0, 0, "fill3");
    cyc(0, 8'h00, 1, 0, 0, "to3a");
    cyc(0, 8'h00, 1, 0, 0, "to3b");
    cyc(1, 8'h55, 0, 1, 0, "flush_wr");
    cyc(0, 8'h00, 0, 0, 1, "err_clr");
    cyc(1, 8'h66, 0, 0, 0, "post_flush_wr");
    cyc(0, 8'h00, 1, 0, 0, "post_flush_rd");

    for (int i = 0; i < 60; i++)
      cyc(1'($urandom), W'($urandom), 1'($urandom), 0,
          1'($urandom_range(0, 7) == 0), "rand");

    while (q.size() > 0) cyc(0, 8'h00, 1, 0, 0, "rand_drain");
    for (int i = 0; i < 4; i++) cyc(1, W'(8'h41 + i), 0, 0, 0, "fill4");
    #3 rst_n = 1'b0;
    #1;
    q.delete(); exp_dout = '0; m_ov = 1'b0; m_un = 1'b0;
    check_all("async_rst");
    #2 rst_n = 1'b1;
    cyc(1, 8'h3C, 0, 0, 0, "wr_3c");
    cyc(0, 8'h00, 1, 0, 0, "rd_3c");
    chk("rd_3c.value", 32'(exp_dout), 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
